// File: rtl/rv32i_types.sv
// Shared RV32I types: base opcode constants and the instruction-queue entry record.
package rv32i_types;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } iq_entry_t;

endpackage

// File: rtl/instr_queue_mem.sv
// Instruction queue storage: one synchronous write port, one asynchronous read port.
// Kept apart from the pointer logic so it can later map onto SRAM or LUTRAM.
module instr_queue_mem
   import rv32i_types::*;
#(
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  iq_entry_t        wdata,
   input  logic [PTR_W-1:0] raddr,
   output iq_entry_t        rdata
);

   iq_entry_t mem [DEPTH];

   // Contents need no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// Circular FIFO between fetch and issue with show-ahead head outputs and
// pre-extracted opcode/funct7 fields for reservation-station steering.
module instr_queue
   import rv32i_types::*;
#(
   parameter  int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           push,
   input  logic [31:0]    push_instr,
   input  logic [31:0]    push_pc,
   output logic           full,
   input  logic           pop,
   output logic           instr_valid,
   output logic [31:0]    instr,
   output logic [31:0]    pc,
   output logic [6:0]     opcode,
   output logic [6:0]     funct7,
   output logic [PTR_W:0] count
);

   logic [PTR_W:0] head;
   logic [PTR_W:0] tail;
   logic           empty;
   logic           push_ok;
   logic           pop_ok;
   iq_entry_t      wr_entry;
   iq_entry_t      head_entry;

   // Flags depend only on the registered pointers; the MSB is the wrap bit.
   assign empty       = (head == tail);
   assign full        = (head[PTR_W-1:0] == tail[PTR_W-1:0]) && (head[PTR_W] != tail[PTR_W]);
   assign instr_valid = !empty;
   assign count       = tail - head;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (push_ok) begin
            tail <= tail + 1'b1;
         end
         if (pop_ok) begin
            head <= head + 1'b1;
         end
      end
   end

   assign wr_entry = '{pc: push_pc, instr: push_instr};

   instr_queue_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok && !flush),
      .waddr (tail[PTR_W-1:0]),
      .wdata (wr_entry),
      .raddr (head[PTR_W-1:0]),
      .rdata (head_entry)
   );

   assign instr  = head_entry.instr;
   assign pc     = head_entry.pc;
   assign opcode = head_entry.instr[6:0];
   assign funct7 = head_entry.instr[31:25];

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: vector table plus hand sequences,
// with a queue scoreboard holding the expected FIFO contents.
module tb_instr_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        push;
   logic [31:0] push_instr;
   logic [31:0] push_pc;
   logic        full;
   logic        pop;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [4:0]  count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;

   sb_t exp_q[$];

   typedef struct {
      logic        p;
      logic [31:0] ppc;
      logic [31:0] pin;
      logic        po;
      logic        fl;
      int          cnt;
      logic        vld;
   } vec_t;

   vec_t vt[9];

   instr_queue #(.DEPTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .push        (push),
      .push_instr  (push_instr),
      .push_pc     (push_pc),
      .full        (full),
      .pop         (pop),
      .instr_valid (instr_valid),
      .instr       (instr),
      .pc          (pc),
      .opcode      (opcode),
      .funct7      (funct7),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Compare flags, occupancy and head entry against the scoreboard.
   task automatic check_output();
      check("count", count, exp_q.size());
      check("instr_valid", instr_valid, exp_q.size() > 0);
      check("full", full, exp_q.size() == 16);
      if (exp_q.size() > 0) begin
         check("head_pc", pc, exp_q[0].pc);
         check("head_instr", instr, exp_q[0].instr);
      end
   endtask

   // Drive one cycle; acceptance is judged from pre-edge occupancy.
   task automatic apply_stimulus(input logic p, input logic [31:0] ppc, input logic [31:0] pin,
                                 input logic po, input logic fl);
      int  pre;
      sb_t e;
      pre        = exp_q.size();
      push       = p;
      push_pc    = ppc;
      push_instr = pin;
      pop        = po;
      flush      = fl;
      if (po && !fl && pre > 0) begin
         e = exp_q.pop_front();
         check("pop_pc", pc, e.pc);
         check("pop_instr", instr, e.instr);
      end
      if (fl) begin
         exp_q.delete();
      end else if (p && pre < 16) begin
         exp_q.push_back('{pc: ppc, instr: pin});
      end
      @(posedge clk);
      #1;
      push  = 1'b0;
      pop   = 1'b0;
      flush = 1'b0;
      check_output();
   endtask

   task automatic drain();
      while (exp_q.size() > 0) begin
         apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      flush      = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      push_pc    = '0;
      push_instr = '0;

      vt[0] = '{1'b1, 32'h0000_0100, 32'h0000_0013, 1'b0, 1'b0, 1, 1'b1};
      vt[1] = '{1'b1, 32'h0000_0104, 32'h0010_0093, 1'b0, 1'b0, 2, 1'b1};
      vt[2] = '{1'b1, 32'h0000_0108, 32'h0020_0113, 1'b1, 1'b0, 2, 1'b1};
      vt[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b1};
      vt[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0};
      vt[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0};
      vt[6] = '{1'b1, 32'h0000_010C, 32'h0030_0193, 1'b1, 1'b0, 1, 1'b1};
      vt[7] = '{1'b1, 32'h0000_0110, 32'h0040_0213, 1'b0, 1'b1, 0, 1'b0};
      vt[8] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset_valid", instr_valid, 1'b0);
      check("reset_full", full, 1'b0);
      check("reset_count", count, 5'd0);
      @(posedge clk);
      #1;
      check_output();

      for (int i = 0; i < 9; i++) begin
         apply_stimulus(vt[i].p, vt[i].ppc, vt[i].pin, vt[i].po, vt[i].fl);
         check("vec_count", count, vt[i].cnt);
         check("vec_valid", instr_valid, vt[i].vld);
      end

      for (int i = 0; i < 16; i++) begin
         apply_stimulus(1'b1, 32'h1000 + 32'(4 * i), 32'h0000_0013, 1'b0, 1'b0);
      end
      check("fill_full", full, 1'b1);
      check("fill_count", count, 5'd16);
      apply_stimulus(1'b1, 32'h0000_1040, 32'h0000_0013, 1'b0, 1'b0);
      check("overflow_count", count, 5'd16);
      for (int i = 0; i < 16; i++) begin
         check("drain_pc", pc, 32'h1000 + 32'(4 * i));
         apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      check("drained_valid", instr_valid, 1'b0);

      for (int i = 0; i < 12; i++) begin
         apply_stimulus(1'b1, 32'h3000 + 32'(4 * i), 32'h0000_0013, 1'b0, 1'b0);
      end
      drain();
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b1, 32'h4000 + 32'(4 * i), 32'h0000_0093, 1'b0, 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         check("wrap_count", count, 5'(10 - i));
         check("wrap_pc", pc, 32'h4000 + 32'(4 * i));
         check("wrap_full", full, 1'b0);
         apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end

      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, 32'h5000 + 32'(4 * i), 32'h0000_0013, 1'b0, 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 32'h5100 + 32'(4 * i), 32'h0000_0013, 1'b1, 1'b0);
         check("simul_count", count, 5'd5);
      end
      drain();
      apply_stimulus(1'b1, 32'h0000_6000, 32'h0000_0013, 1'b1, 1'b0);
      check("empty_both_count", count, 5'd1);
      check("empty_both_pc", pc, 32'h0000_6000);
      drain();

      for (int i = 0; i < 7; i++) begin
         apply_stimulus(1'b1, 32'h0000_1800 + 32'(4 * i), 32'h0000_0013, 1'b0, 1'b0);
      end
      apply_stimulus(1'b1, 32'h0000_2000, 32'h0000_0013, 1'b0, 1'b1);
      check("flush_count", count, 5'd0);
      check("flush_valid", instr_valid, 1'b0);
      check("flush_no_2000", pc != 32'h0000_2000, 1'b1);
      apply_stimulus(1'b1, 32'h0000_7000, 32'h0000_0013, 1'b0, 1'b0);
      check("post_flush_pc", pc, 32'h0000_7000);
      drain();

      apply_stimulus(1'b1, 32'h0000_8000, 32'h02B5_0533, 1'b0, 1'b0);
      check("mul_opcode", opcode, 7'b0110011);
      check("mul_funct7", funct7, 7'b0000001);
      drain();
      apply_stimulus(1'b1, 32'h0000_8004, 32'h00C0_00EF, 1'b0, 1'b0);
      check("jal_opcode", opcode, 7'b1101111);
      drain();

      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 32'h0000_9000 + 32'(4 * i), 32'h0000_0013, 1'b0, 1'b0);
      end
      check("pre_reset_count", count, 5'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_count", count, 5'd0);
      check("async_reset_valid", instr_valid, 1'b0);
      #2;
      rst_n = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      check_output();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_queue.md
# instr_queue

Circular FIFO between fetch and issue. Buffers fetched instructions and their PCs, and presents the oldest entry to the issue control logic. Issue pops the entry once a reservation station and a ROB slot accept it. Also pre-extracts the `opcode` and `funct7` fields that issue uses to steer each instruction to a reservation station.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`, index width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  discard all entries (branch mispredict / ROB flush).
- `push`  in  1  fetch writes one entry this cycle.
- `push_instr`  in  32  instruction word to enqueue.
- `push_pc`  in  32  PC of that instruction.
- `full`  out  1  queue holds `DEPTH` entries.
- `pop`  in  1  issue consumes the head entry this cycle (`instr_pop`).
- `instr_valid`  out  1  head entry present (queue not empty).
- `instr`  out  32  head instruction word.
- `pc`  out  32  head PC.
- `opcode`  out  7  `instr[6:0]`.
- `funct7`  out  7  `instr[31:25]`.
- `count`  out  `PTR_W+1`  current occupancy, 0..`DEPTH`.

## Operation
- Storage: `DEPTH` entries of {pc, instr}. Head pointer and tail pointer are each `PTR_W+1` bits. The MSB is the wrap bit.
- Empty: head == tail. Full: indices equal and wrap bits differ. `count` = tail − head, modulo 2^(`PTR_W+1`).
- Accepted push: `push && !full`. Writes `entries[tail[PTR_W-1:0]]`; tail increments.
- Accepted pop: `pop && instr_valid`. Head increments. Entry contents are not cleared.
- Push while full is dropped, even if pop is asserted in the same cycle. `full` is computed from current state only, so fetch must stall on `full`.
- Pop while empty is dropped, even if push is asserted in the same cycle. The pushed entry becomes visible next cycle.
- Push and pop both accepted in one cycle: both pointers advance, `count` unchanged.
- Pointers wrap naturally through the wrap bit. No special case at index `DEPTH-1`.
- `flush` has priority over push and pop in the same cycle. Head ← 0, tail ← 0, and the push in that cycle is discarded.
- Head outputs (`instr`, `pc`, `opcode`, `funct7`) are combinational reads of `entries[head]`, i.e. show-ahead. They hold stale data when `instr_valid` = 0; consumers qualify them with `instr_valid`.

## Timing
- Reset (async assert, sync release by system): head = tail = 0. Outputs after reset: `instr_valid` = 0, `full` = 0, `count` = 0. Entry contents are don't-care; no reset is required on the array.
- Push-to-visible latency: 1 cycle. An entry pushed at edge N drives `instr_valid` = 1 after edge N.
- Pop effect: the next entry appears on the head outputs immediately after the popping edge, so pops can sustain 1 per cycle.
- `full`, `instr_valid` and `count` are pure functions of registered pointers. There is no combinational path from `push`, `pop` or `flush` to any output.
- Flush takes effect at the next edge. In the cycle `flush` is high, outputs still reflect the pre-flush state; issue must gate `pop` with `flush` itself.
- Reset asserted mid-operation: pointers clear immediately, without waiting for a clock edge.

## Structure
- Add `iq_entry_t` (packed {`logic [31:0] pc; logic [31:0] instr;`}) to `rv32i_types`. Opcode constants already live there; the block needs none of its own.
- One sub-module: `instr_queue_mem`, a `DEPTH`×64 array with one synchronous write port and one asynchronous read port. It keeps the array separable for later SRAM or LUTRAM mapping.
- Pointer, flag and count logic live in `instr_queue` itself. Target size is about 150 lines of RTL.

## Test plan
- Reset, then idle → `instr_valid` = 0, `full` = 0, `count` = 0. Pulse `rst_n` low between clock edges while holding 3 entries → `count` = 0 immediately.
- Push 16 entries with `push_pc` = 0x1000 + 4i and `push_instr` = 0x00000013 (addi) → after the 16th edge, `full` = 1 and `count` = 16. A 17th push (pc 0x1040) is dropped. Draining returns pcs 0x1000..0x103C in order.
- Wrap-around: push 12, pop 12, push 10 → pcs pop in order across the index-15→0 boundary. `count` tracks 10→0 with no false `full`.
- Simultaneous push and pop: at `count` = 5, assert both for 8 cycles → `count` stays 5 and FIFO order is preserved. On empty with both asserted → pop is ignored and `count` = 1 next cycle.
- Flush with push: at `count` = 7, assert `flush` and `push` (pc 0x2000) in the same cycle → next cycle `count` = 0 and `instr_valid` = 0, and 0x2000 is never observed.
- Field extraction: push 0x02B50533 (mul, R-type, funct7 = 0000001) → `opcode` = 0110011 and `funct7` = 0000001 while at head. Push 0x00C000EF (jal) → `opcode` = 1101111.
